result_uart_tx: RTL and testbench
=================================

// Module: result_uart_tx
// PURPOSE
//  Host-side reporter for the processor's 32-bit result bus (driven by the microarchitecture's out port).
//  Watches the word, snapshots it on change or on request, and streams it as ASCII hex over an
//  8N1 UART line: 8 uppercase hex digits MSB-nibble first, then CR (0x0D), LF (0x0A).
//  Sits beside the core in the top level. Lets a board or bench read results without waveforms.
// PARAMETERS
//  CLK_DIV   16  clock cycles per UART bit; legal range 2..65535
//  CNT_W     16  width of sent_cnt
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      asynchronous, active-high reset
//  result    in   32     word to report (processor out bus)
//  en        in   1      1 = change detection armed; 0 = only send_req triggers a frame
//  send_req  in   1      1-cycle pulse: report current result regardless of change
//  tx        out  1      UART serial line, idle high
//  busy      out  1      1 while a frame (10 chars) is in flight
//  sent_cnt  out  CNT_W  frames completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async): tx=1, busy=0, sent_cnt=0, last_seen=0, pending=0, FSM=IDLE. Asserting rst mid-frame
//   drives tx high immediately and aborts the frame. The aborted frame does not count.
//  Trigger at edge k: (en && result!=last_seen) || send_req.
//  IDLE + trigger at edge k: snap<=result, last_seen<=result, busy<=1, FSM<=START, tx<=0 (start bit
//   visible from edge k). There is no added latency.
//  Per character: START (tx=0) -> DATA bits 0..7 LSB first -> STOP (tx=1). Each bit holds exactly
//   CLK_DIV cycles. The bit counter and divider reset at each bit boundary.
//  Char index 0..9: idx 0..7 = hex(snap[31-4*idx -: 4]), '0'-'9'=0x30-0x39, 'A'-'F'=0x41-0x46.
//   idx 8=0x0D, idx 9=0x0A. There is no idle gap between characters: the next START follows the STOP.
//  Frame length is exactly 10*10*CLK_DIV cycles from start edge to the edge that ends the last STOP.
//  At that edge: sent_cnt<=sent_cnt+1.
//   If pending: reload snap from the pending shadow and start the next frame the same edge. busy stays 1.
//   Otherwise go to IDLE and set busy<=0.
//  Trigger while busy: pending<=1, shadow<=result, last_seen<=result. A later trigger overwrites the
//   shadow, so only the newest value is queued (depth 1). The frame in flight is never altered.
//  Trigger on the same edge the frame ends: counts as pending. The back-to-back frame carries the new value.
//  en low: last_seen still tracks result. Re-enabling does not emit stale changes.
//  At most one frame starts per edge. send_req held high retriggers continuously; callers must pulse it.
// STRUCTURE
//  Shared header io_defs.vh: ASCII_CR, ASCII_LF, NUM_CHARS=10, BITS_PER_CHAR=10, hex2ascii function.
//  Sub-module uart_tx_byte (CLK_DIV param):
//   - in: start, data[7:0]
//   - out: tx, done (1-cycle pulse at end of STOP)
//   - owns the divider and the bit FSM.
//  Top level owns:
//   - frame FSM: IDLE / SEND
//   - char index
//   - snapshot, shadow, pending, last_seen
//   - sent_cnt
// TESTING  (CLK_DIV=4, so one char = 40 cycles and one frame = 400 cycles)
//  1. Reset, then result=0x0000002A, en=1. Decoded chars = "0000002A\r\n". busy=1 for exactly 400
//     cycles. sent_cnt=1. tx=1 afterwards.
//  2. result=0xDEADBEEF. Decoded chars = "DEADBEEF\r\n". Digit bytes are 0x44,0x45,0x41,0x44,0x42,0x45,
//     0x45,0x46.
//  3. Mid-frame, set result=0x1, then 0x2. Exactly two frames: the original, then "00000002\r\n"
//     back-to-back (no idle cycle). sent_cnt increments by 2.
//  4. en=0, result toggles. No frame is sent. Pulse send_req once: one frame with the current value.
//     Re-enable with result unchanged: no frame.
//  5. Assert rst at cycle 150 of a frame. tx=1 asynchronously, busy=0, sent_cnt=0. After release with
//     result!=0, a full frame restarts.
//  6. sent_cnt wrap with CNT_W=2: after 4 frames sent_cnt=0. Line check: every start bit is 0 and every
//     stop bit is 1 for exactly 4 cycles.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result reporter: ASCII constants, FSM encodings
// and the character generator used to turn a 32-bit word into a text line.
package result_uart_tx_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         NUM_CHARS = 10;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_SEND = 1'b1
  } frame_state_e;

  typedef enum logic [1:0] {
    BIT_IDLE  = 2'd0,
    BIT_START = 2'd1,
    BIT_DATA  = 2'd2,
    BIT_STOP  = 2'd3
  } bit_state_e;

  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Character idx of the line for word: 8 hex digits MSB-nibble first, then CR, LF.
  function automatic logic [7:0] frame_char(input logic [31:0] word, input logic [3:0] idx);
    logic [31:0] sh;
    sh = word << {idx[2:0], 2'b00};
    if (idx == 4'd8)      return ASCII_CR;
    else if (idx == 4'd9) return ASCII_LF;
    else                  return hex2ascii(sh[31:28]);
  endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// 8N1 byte serializer. start_i is sampled in IDLE or in the last STOP cycle so
// characters can be chained with no idle gap; done_o flags that last STOP cycle.
module result_uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o,
  output bit_state_e state_o
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  bit_state_e  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_last;

  assign bit_last = (div_q == DIV_LAST);
  assign done_o   = (state_q == BIT_STOP) && bit_last;
  assign tx_o     = tx_q;
  assign state_o  = state_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    div_d   = (state_q == BIT_IDLE || bit_last) ? 16'd0 : div_q + 16'd1;
    case (state_q)
      BIT_IDLE: begin
        if (start_i) begin
          state_d = BIT_START;
          tx_d    = 1'b0;
          shift_d = data_i;
        end
      end
      BIT_START: begin
        if (bit_last) begin
          state_d = BIT_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      BIT_DATA: begin
        if (bit_last) begin
          if (bit_q == 3'd7) begin
            state_d = BIT_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      BIT_STOP: begin
        if (bit_last) begin
          if (start_i) begin
            state_d = BIT_START;
            tx_d    = 1'b0;
            shift_d = data_i;
          end else begin
            state_d = BIT_IDLE;
          end
        end
      end
      default: state_d = BIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BIT_IDLE;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Reports the processor result word as a hex text line over UART whenever it
// changes (en=1) or on send_req; one newer value can be queued behind a frame.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      result,
  input  logic             en,
  input  logic             send_req,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output frame_state_e     dbg_frame_state_o,
  output bit_state_e       dbg_bit_state_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CHARS - 1);

  frame_state_e     state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      last_seen_q, last_seen_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        trigger, frame_end;
  logic        byte_start, byte_done;
  logic [7:0]  byte_data;
  logic [31:0] next_word;

  assign trigger   = (en && (result != last_seen_q)) || send_req;
  assign frame_end = byte_done && (idx_q == LAST_IDX);

  // The first character of a frame is taken straight from the word being
  // latched this edge, so the start bit appears with no extra cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    last_seen_d = result;
    byte_start  = 1'b0;
    byte_data   = 8'h00;
    next_word   = shadow_q;
    case (state_q)
      FRAME_IDLE: begin
        if (trigger) begin
          byte_start = 1'b1;
          byte_data  = frame_char(result, 4'd0);
          snap_d     = result;
          idx_d      = 4'd0;
          state_d    = FRAME_SEND;
        end
      end
      FRAME_SEND: begin
        if (frame_end) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pending_q || trigger) begin
            next_word  = trigger ? result : shadow_q;
            byte_start = 1'b1;
            byte_data  = frame_char(next_word, 4'd0);
            snap_d     = next_word;
            idx_d      = 4'd0;
            pending_d  = 1'b0;
          end else begin
            state_d = FRAME_IDLE;
          end
        end else begin
          if (byte_done) begin
            byte_start = 1'b1;
            idx_d      = idx_q + 4'd1;
            byte_data  = frame_char(snap_q, idx_q + 4'd1);
          end
          if (trigger) begin
            pending_d = 1'b1;
            shadow_d  = result;
          end
        end
      end
      default: state_d = FRAME_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FRAME_IDLE;
      idx_q       <= 4'd0;
      snap_q      <= 32'h0;
      shadow_q    <= 32'h0;
      last_seen_q <= 32'h0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      shadow_q    <= shadow_d;
      last_seen_q <= last_seen_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
    end
  end

  result_uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_byte (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (byte_start),
    .data_i  (byte_data),
    .tx_o    (tx),
    .done_o  (byte_done),
    .state_o (dbg_bit_state_o)
  );

  assign busy              = (state_q == FRAME_SEND);
  assign sent_cnt          = cnt_q;
  assign dbg_frame_state_o = state_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx with CLK_DIV=4 (400-cycle frames) and a 2-bit frame counter.
module tb_result_uart_tx;
  import result_uart_tx_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 2;

  typedef struct {
    logic [31:0] value;
    logic [63:0] digits;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      result;
  logic             en;
  logic             send_req;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] sent_cnt;
  frame_state_e     dbg_frame;
  bit_state_e       dbg_bit;

  result_uart_tx #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .result            (result),
    .en                (en),
    .send_req          (send_req),
    .tx                (tx),
    .busy              (busy),
    .sent_cnt          (sent_cnt),
    .dbg_frame_state_o (dbg_frame),
    .dbg_bit_state_o   (dbg_bit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         frames_started = 0;
  logic       prev_busy = 1'b0;
  int         exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting on busy", name);
  endtask

  task automatic expect_chars(input logic [63:0] digits, input int n, input bit with_crlf);
    for (int i = 0; i < n; i++) exp_q.push_back(digits[63-8*i -: 8]);
    if (with_crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic score_char(input logic [7:0] rx, input logic framing_ok);
    logic [7:0] e;
    check("char framing (start 4x0 / stop 4x1)", {31'b0, framing_ok}, 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL rx char: got unexpected 0x%02h, expected no character", rx);
    end else begin
      e = exp_q.pop_front();
      check("rx char", {24'b0, rx}, {24'b0, e});
    end
  endtask

  // Busy-length and frame-start tracker.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        busy_run  = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy === 1'b1 && prev_busy !== 1'b1) frames_started++;
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
          last_busy_len = busy_run;
          busy_run      = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // UART line decoder: samples every cycle of each 4-cycle bit.
  initial begin
    int         pos;
    int         b;
    int         c;
    logic       active;
    logic       ok;
    logic [7:0] byte_v;
    active = 1'b0;
    pos    = 0;
    ok     = 1'b1;
    byte_v = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          pos    = 0;
          ok     = 1'b1;
          byte_v = 8'h00;
        end
        if (active) begin
          b = pos / CLK_DIV;
          c = pos % CLK_DIV;
          if (b == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (b <= 8) begin
            if (c == 0) byte_v[b-1] = tx;
            else if (tx !== byte_v[b-1]) ok = 1'b0;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
          end
          pos++;
          if (pos == 10 * CLK_DIV) begin
            active = 1'b0;
            score_char(byte_v, ok);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frames(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) begin
      timeout_fail({name, " start"});
    end else begin
      check({name, " frame fsm in SEND"}, {31'b0, dbg_frame}, 32'd1);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (busy === 1'b1) timeout_fail({name, " end"});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post_checks(input string name, input int exp_len);
    check({name, " busy length"}, last_busy_len, exp_len);
    check({name, " sent_cnt"}, 32'(sent_cnt), 32'(exp_cnt % 4));
    check({name, " tx idle high"}, {31'b0, tx}, 32'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs[5];
  int   frames_before;

  initial begin
    vecs[0].value = 32'h0000002A; vecs[0].digits = "0000002A";
    vecs[1].value = 32'hDEADBEEF; vecs[1].digits = "DEADBEEF";
    vecs[2].value = 32'h13579BDF; vecs[2].digits = "13579BDF";
    vecs[3].value = 32'hFFFFFFFF; vecs[3].digits = "FFFFFFFF";
    vecs[4].value = 32'h00000000; vecs[4].digits = "00000000";

    rst      = 1'b1;
    en       = 1'b1;
    send_req = 1'b0;
    result   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", {31'b0, tx}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset sent_cnt", 32'(sent_cnt), 32'd0);
    check("reset frame fsm", {31'b0, dbg_frame}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no frame for unchanged zero", frames_started, 0);

    // Single frames on change; the fourth one wraps the 2-bit counter to 0.
    for (int i = 0; i < 5; i++) begin
      expect_chars(vecs[i].digits, 8, 1'b1);
      result = vecs[i].value;
      wait_frames("table");
      exp_cnt++;
      post_checks("table", 400);
    end

    // Two changes mid-frame: only the newest is queued and follows back-to-back.
    expect_chars("11111111", 8, 1'b1);
    expect_chars("00000002", 8, 1'b1);
    result = 32'h11111111;
    repeat (100) @(posedge clk);
    #1 result = 32'h00000001;
    repeat (5) @(posedge clk);
    #1 result = 32'h00000002;
    wait_frames("pending overwrite");
    exp_cnt += 2;
    post_checks("pending overwrite", 800);

    // Change sampled on the very edge that ends the frame.
    expect_chars("0000ABCD", 8, 1'b1);
    expect_chars("0000BEEF", 8, 1'b1);
    result = 32'h0000ABCD;
    repeat (400) @(posedge clk);
    #1 result = 32'h0000BEEF;
    wait_frames("trigger at frame end");
    exp_cnt += 2;
    post_checks("trigger at frame end", 800);

    // en low: changes ignored, send_req reports, re-enable emits nothing stale.
    en            = 1'b0;
    frames_before = frames_started;
    result        = 32'h00000005;
    repeat (3) @(posedge clk);
    #1 result = 32'h00000006;
    repeat (3) @(posedge clk);
    #1 result = 32'h00000007;
    repeat (20) @(posedge clk);
    #1;
    check("en=0 no frame", frames_started, frames_before);
    check("en=0 busy low", {31'b0, busy}, 32'd0);
    expect_chars("00000007", 8, 1'b1);
    send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    wait_frames("send_req");
    exp_cnt++;
    post_checks("send_req", 400);
    check("send_req one frame", frames_started, frames_before + 1);
    en = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("re-enable no stale frame", frames_started, frames_before + 1);

    // Reset 150 cycles into a frame: 3 chars complete, the rest is aborted.
    expect_chars("12345678", 3, 1'b0);
    result = 32'h12345678;
    repeat (150) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-frame reset tx", {31'b0, tx}, 32'd1);
    check("mid-frame reset busy", {31'b0, busy}, 32'd0);
    check("mid-frame reset sent_cnt", 32'(sent_cnt), 32'd0);
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    expect_chars("12345678", 8, 1'b1);
    #1 rst = 1'b0;
    wait_frames("restart after reset");
    exp_cnt++;
    post_checks("restart after reset", 400);

    repeat (10) @(posedge clk);
    #1;
    check("expected chars drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
